seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 169 ++++++++++++++++
 tb/tb_seq_alu.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/add/sub/compare ops plus a WIDTH-cycle shift-add multiply,
// with a valid/ready handshake on both sides and a result held until the consumer takes it.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             Cout,
    output logic             zero_f,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    localparam logic [2:0] OP_AND = 3'd0, OP_OR  = 3'd1, OP_ADD = 3'd2, OP_XOR = 3'd3,
                           OP_SUB = 3'd4, OP_SLT = 3'd5, OP_MUL = 3'd6, OP_NOR = 3'd7;

    state_t               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d, acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;

    logic                 is_sub;
    logic [WIDTH-1:0]     b_eff, add_v;
    logic [WIDTH:0]       sum_w;
    logic                 add_c, add_ovf;
    logic signed [WIDTH-1:0] add_s;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_cout, alu_ovf;
    logic [2*WIDTH-1:0]   step_acc;

    // Two's-complement overflow: operands agree in sign but the sum does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign Cout      = cout_q;
    assign zero_f    = zero_q;
    assign overflow  = ovf_q;

    // Shared adder: SUB and SLT feed ~B with a carry-in of one.
    always_comb begin
        is_sub  = (opcode == OP_SUB) || (opcode == OP_SLT);
        b_eff   = is_sub ? ~B : B;
        sum_w   = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        add_v   = sum_w[WIDTH-1:0];
        add_c   = sum_w[WIDTH];
        add_s   = signed'(add_v);
        add_ovf = signed_ovf(A[WIDTH-1], b_eff[WIDTH-1], add_v[WIDTH-1]);
    end

    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (opcode)
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_NOR: alu_res = ~(A | B);
            OP_ADD, OP_SUB: begin
                alu_res  = add_v;
                alu_cout = add_c;
                alu_ovf  = add_ovf;
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, (add_s < 0) ^ add_ovf};
            default: alu_res = '0;
        endcase
    end

    assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        cout_d      = cout_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (opcode == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, A};
                        mplier_d = B;
                        acc_d    = '0;
                        cnt_d    = CNT_W'(WIDTH);
                        state_d  = BUSY;
                    end else begin
                        result_d    = alu_res;
                        cout_d      = alu_cout;
                        ovf_d       = alu_ovf;
                        zero_d      = (alu_res == '0);
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            BUSY: begin
                acc_d    = step_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d    = step_acc[WIDTH-1:0];
                    cout_d      = 1'b0;
                    ovf_d       = |step_acc[2*WIDTH-1:WIDTH];
                    zero_d      = (step_acc[WIDTH-1:0] == '0);
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    // Multiply datapath is only meaningful in BUSY, so it carries no reset.
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed cases on a 32-bit instance, scoreboarded random traffic on 32- and 8-bit instances.
module tb_seq_alu;

    typedef struct {
        logic [63:0] res;
        logic        cout;
        logic        zero;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [31:0] a = '0, b = '0, result;
    logic [2:0]  opcode = '0;
    logic        cout, zero_f, overflow;

    logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0, result8;
    logic [2:0]  opcode8 = '0;
    logic        cout8, zero_f8, overflow8;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
        .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .Cout(cout), .zero_f(zero_f), .overflow(overflow)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .A(a8), .B(b8),
        .opcode(opcode8), .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
        .Cout(cout8), .zero_f(zero_f8), .overflow(overflow8)
    );

    function automatic exp_t model(input int w, input logic [2:0] op, input logic [63:0] ai, input logic [63:0] bi);
        exp_t e;
        logic [63:0] mask, x, y;
        logic [64:0] full;
        logic [127:0] p;
        logic signed [63:0] xs, ys;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        x = ai & mask;
        y = bi & mask;
        e.res = '0; e.cout = 1'b0; e.ovf = 1'b0;
        case (op)
            3'd0: e.res = x & y;
            3'd1: e.res = x | y;
            3'd3: e.res = x ^ y;
            3'd7: e.res = ~(x | y) & mask;
            3'd2: begin
                full  = {1'b0, x} + {1'b0, y};
                e.res = full[63:0] & mask;
                e.cout = full[w];
                e.ovf = (x[w-1] == y[w-1]) && (e.res[w-1] != x[w-1]);
            end
            3'd4: begin
                full  = {1'b0, x} + {1'b0, (~y & mask)} + 65'd1;
                e.res = full[63:0] & mask;
                e.cout = full[w];
                e.ovf = (x[w-1] != y[w-1]) && (e.res[w-1] != x[w-1]);
            end
            3'd5: begin
                xs = signed'(x << (64 - w)) >>> (64 - w);
                ys = signed'(y << (64 - w)) >>> (64 - w);
                e.res = (xs < ys) ? 64'd1 : 64'd0;
            end
            default: begin
                p = {64'd0, x} * {64'd0, y};
                e.res = p[63:0] & mask;
                e.ovf = ((p >> w) != 128'd0);
            end
        endcase
        e.zero = (e.res == 64'd0);
        return e;
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return mask;
            2: return 64'd1 << (w - 1);
            3: return mask >> 1;
            4: return 64'($urandom_range(1, 20));
            default: return {$urandom(), $urandom()} & mask;
        endcase
    endfunction

    task automatic send(input logic [2:0] op, input logic [31:0] ai, input logic [31:0] bi);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        opcode = op; a = ai; b = bi; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out_valid, result, cout, zero_f, overflow} !== 36'd0) begin
            $display("FAIL reset_state: got v=%b r=%h c=%b z=%b o=%b, want all 0", out_valid, result, cout, zero_f, overflow);
            n_fail++;
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, result} !== {1'b1, 1'b0, 32'd0}) begin
            $display("FAIL reset_release: got rdy=%b v=%b r=%h, want rdy=1 v=0 r=0", in_ready, out_valid, result);
            n_fail++;
        end
    endtask

    task automatic test_alu_op(input string name, input logic [2:0] op, input logic [31:0] ai, input logic [31:0] bi,
                               input logic [31:0] r_exp, input logic c_exp, input logic z_exp, input logic o_exp);
        int lat;
        out_ready = 1'b1;
        send(op, ai, bi);
        wait_out(lat);
        n_checks++;
        if ({lat, result, cout, zero_f, overflow} !== {32'd1, r_exp, c_exp, z_exp, o_exp}) begin
            $display("FAIL %s: got lat=%0d r=%h c=%b z=%b o=%b, want lat=1 r=%h c=%b z=%b o=%b",
                     name, lat, result, cout, zero_f, overflow, r_exp, c_exp, z_exp, o_exp);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL %s_release: got v=%b rdy=%b, want v=0 rdy=1", name, out_valid, in_ready);
            n_fail++;
        end
    endtask

    task automatic test_mul(input string name, input logic [31:0] ai, input logic [31:0] bi,
                            input logic [31:0] r_exp, input logic z_exp, input logic o_exp);
        int lat;
        out_ready = 1'b1;
        send(3'd6, ai, bi);
        wait_out(lat);
        n_checks++;
        if ({lat, result, cout, zero_f, overflow} !== {32'd33, r_exp, 1'b0, z_exp, o_exp}) begin
            $display("FAIL %s: got lat=%0d r=%h c=%b z=%b o=%b, want lat=33 r=%h c=0 z=%b o=%b",
                     name, lat, result, cout, zero_f, overflow, r_exp, z_exp, o_exp);
            n_fail++;
        end
        @(negedge clk);
    endtask

    task automatic test_hold_backpressure();
        int lat, seen;
        out_ready = 1'b0;
        send(3'd0, 32'hF0F0F0F0, 32'hFF00FF00);
        in_valid = 1'b1; opcode = 3'd1; a = 32'h1234_5678; b = 32'h0F0F_0F0F;
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'hF000F000}) begin
                $display("FAIL hold_cycle%0d: got v=%b rdy=%b r=%h, want v=1 rdy=0 r=f000f000", i, out_valid, in_ready, result);
                n_fail++;
            end
            a = a + 32'd1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            $display("FAIL hold_single_delivery: got %0d extra valid cycles, want 0", seen);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        out_ready = 1'b1;
        send(3'd6, 32'd1234, 32'd5678);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 32'd0}) begin
            $display("FAIL mid_mul_reset: got v=%b rdy=%b r=%h, want v=0 rdy=1 r=0", out_valid, in_ready, result);
            n_fail++;
        end
        send(3'd2, 32'd2, 32'd3);
        wait_out(lat);
        n_checks++;
        if ({lat, result} !== {32'd1, 32'd5}) begin
            $display("FAIL add_after_reset: got lat=%0d r=%0d, want lat=1 r=5", lat, result);
            n_fail++;
        end
        @(negedge clk);
    endtask

    task automatic test_random_w32(input int n_cmds);
        exp_t q[$];
        exp_t e;
        int sent = 0;
        int cyc = 0;
        while ((sent < n_cmds || q.size() > 0) && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL rand32_dup: got unexpected result %h, want none", result);
                    n_fail++;
                end else begin
                    e = q.pop_front();
                    if ({result, cout, zero_f, overflow} !== {e.res[31:0], e.cout, e.zero, e.ovf}) begin
                        $display("FAIL rand32_result: got r=%h c=%b z=%b o=%b, want r=%h c=%b z=%b o=%b",
                                 result, cout, zero_f, overflow, e.res[31:0], e.cout, e.zero, e.ovf);
                        n_fail++;
                    end
                end
            end
            in_valid = (sent < n_cmds) && ($urandom_range(0, 3) != 0);
            opcode = 3'($urandom_range(0, 7));
            a = 32'(pick(32));
            b = 32'(pick(32));
            if (in_valid && in_ready) begin
                q.push_back(model(32, opcode, {32'd0, a}, {32'd0, b}));
                sent++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (q.size() != 0 || sent != n_cmds || out_valid !== 1'b0) begin
            $display("FAIL rand32_drain: got pending=%0d sent=%0d v=%b, want pending=0 sent=%0d v=0", q.size(), sent, out_valid, n_cmds);
            n_fail++;
        end
    endtask

    task automatic test_random_w8(input int n_cmds);
        exp_t q[$];
        exp_t e;
        int sent = 0;
        int cyc = 0;
        while ((sent < n_cmds || q.size() > 0) && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            out_ready8 = ($urandom_range(0, 2) != 0);
            if (out_valid8 && out_ready8) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL rand8_dup: got unexpected result %h, want none", result8);
                    n_fail++;
                end else begin
                    e = q.pop_front();
                    if ({result8, cout8, zero_f8, overflow8} !== {e.res[7:0], e.cout, e.zero, e.ovf}) begin
                        $display("FAIL rand8_result: got r=%h c=%b z=%b o=%b, want r=%h c=%b z=%b o=%b",
                                 result8, cout8, zero_f8, overflow8, e.res[7:0], e.cout, e.zero, e.ovf);
                        n_fail++;
                    end
                end
            end
            in_valid8 = (sent < n_cmds) && ($urandom_range(0, 3) != 0);
            opcode8 = 3'($urandom_range(0, 7));
            a8 = 8'(pick(8));
            b8 = 8'(pick(8));
            if (in_valid8 && in_ready8) begin
                q.push_back(model(8, opcode8, {56'd0, a8}, {56'd0, b8}));
                sent++;
            end
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (q.size() != 0 || sent != n_cmds || out_valid8 !== 1'b0) begin
            $display("FAIL rand8_drain: got pending=%0d sent=%0d v=%b, want pending=0 sent=%0d v=0", q.size(), sent, out_valid8, n_cmds);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_alu_op("add_carry", 3'd2, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b1, 1'b0);
        test_alu_op("add_ovf", 3'd2, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b0, 1'b1);
        test_alu_op("sub_borrow", 3'd4, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        test_alu_op("slt_neg", 3'd5, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        test_alu_op("nor_zero", 3'd7, 32'hFFFF0000, 32'h0000FFFF, 32'd0, 1'b0, 1'b1, 1'b0);
        test_alu_op("xor", 3'd3, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b0);
        test_mul("mul_wrap", 32'h00010000, 32'h00010000, 32'd0, 1'b1, 1'b1);
        test_mul("mul_basic", 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0);
        test_mul("mul_zero", 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);
        test_hold_backpressure();
        test_reset_mid_mul();
        test_random_w32(150);
        test_random_w8(300);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
